wb_stage: RTL and testbench

Writeback stage of the five-stage MIPS pipeline; the writer side of the register-file write port consumed by the decode stage (GPR, HI/LO, CP0 via 7-bit register address). Holds the MEM/WB pipeline register, waits for late data-cache load responses, aligns load data (LB/LBU/LH/LHU/LW/LWL/LWR) and produces the write address, data and byte enables exactly once per retired instruction. Also supplies the WB forwarding value and a stall request to the hazard unit.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/wb_stage_if.sv | 39 +++
 rtl/load_align.sv | 46 ++++
 rtl/wb_stage.sv | 130 +++++++++++++
 tb/tb_wb_stage.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings for the MIPS pipeline writeback path
package mips_pkg;

  typedef enum logic [2:0] {
    MRT_LW  = 3'd0,
    MRT_LB  = 3'd1,
    MRT_LBU = 3'd2,
    MRT_LH  = 3'd3,
    MRT_LHU = 3'd4,
    MRT_LWL = 3'd5,
    MRT_LWR = 3'd6
  } mem_read_t;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_WAIT  = 2'd1,
    WB_DRAIN = 2'd2
  } wb_state_t;

  localparam logic [3:0] BYTE_WE_ALL = 4'b1111;

endpackage

// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - MEM/WB bus: MEM-side instruction fields, cache response, register write port
interface wb_stage_if;
  logic        ValidM;
  logic        RegWriteM;
  logic        MemtoRegM;
  logic [2:0]  MemReadTypeM;
  logic [1:0]  AddrLowM;
  logic [6:0]  WriteRegM;
  logic [31:0] ALUOutM;
  logic        HI_LO_write_enableM;
  logic [63:0] HI_LO_dataM;
  logic        StallW;
  logic        FlushW;
  logic        rdata_ok;
  logic [31:0] rdata;

  logic        RegWriteW;
  logic [6:0]  WriteRegW;
  logic [31:0] ResultW;
  logic [3:0]  reg_file_byte_we;
  logic        HI_LO_write_enable_from_WB;
  logic [63:0] HI_LO_data;
  logic [31:0] ForwardWB;
  logic        wb_stall_req;

  modport master (
    output ValidM, RegWriteM, MemtoRegM, MemReadTypeM, AddrLowM, WriteRegM, ALUOutM,
           HI_LO_write_enableM, HI_LO_dataM, StallW, FlushW, rdata_ok, rdata,
    input  RegWriteW, WriteRegW, ResultW, reg_file_byte_we, HI_LO_write_enable_from_WB,
           HI_LO_data, ForwardWB, wb_stall_req
  );

  modport slave (
    input  ValidM, RegWriteM, MemtoRegM, MemReadTypeM, AddrLowM, WriteRegM, ALUOutM,
           HI_LO_write_enableM, HI_LO_dataM, StallW, FlushW, rdata_ok, rdata,
    output RegWriteW, WriteRegW, ResultW, reg_file_byte_we, HI_LO_write_enable_from_WB,
           HI_LO_data, ForwardWB, wb_stall_req
  );
endinterface

// File: rtl/load_align.sv
// rtl/load_align.sv - load data extraction/extension and partial-word byte enables
module load_align
  import mips_pkg::*;
(
  input  logic [2:0]  mem_read_type_i,
  input  logic [1:0]  addr_low_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] alu_out_i,
  input  logic        mem_to_reg_i,
  output logic [31:0] data_o,
  output logic [3:0]  byte_we_o
);

  logic [4:0]  sh_r;
  logic [4:0]  sh_l;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    sh_r     = {addr_low_i, 3'b000};
    // 8*(3-k) equals 8*~k for a two-bit k
    sh_l     = {~addr_low_i, 3'b000};
    byte_sel = rdata_i[sh_r +: 8];
    half_sel = addr_low_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    data_o    = alu_out_i;
    byte_we_o = BYTE_WE_ALL;
    if (mem_to_reg_i) begin
      case (mem_read_t'(mem_read_type_i))
        MRT_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
        MRT_LBU: data_o = {24'h0, byte_sel};
        MRT_LH:  data_o = {{16{half_sel[15]}}, half_sel};
        MRT_LHU: data_o = {16'h0, half_sel};
        MRT_LWL: begin
          data_o    = rdata_i << sh_l;
          byte_we_o = BYTE_WE_ALL << ~addr_low_i;
        end
        MRT_LWR: begin
          data_o    = rdata_i >> sh_r;
          byte_we_o = BYTE_WE_ALL >> addr_low_i;
        end
        default: data_o = rdata_i;
      endcase
    end
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB register, late load response tracking and single-shot register writeback
module wb_stage
  import mips_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  wb_stage_if.slave wb
);

  logic        valid_q;
  logic        regwrite_q;
  logic        memtoreg_q;
  logic [2:0]  mrt_q;
  logic [1:0]  addr_low_q;
  logic [6:0]  wreg_q;
  logic [31:0] alu_q;
  logic        hilo_we_q;
  logic [63:0] hilo_q;
  logic        done_q;
  logic [31:0] buf_q;
  logic        buf_valid_q;
  wb_state_t   state_q;

  logic        load_held;
  logic        rsp_live;
  logic        data_ready;
  logic        commit;
  logic        abandon;
  logic        next_load_pending;
  logic [31:0] load_rdata;
  logic [31:0] align_data;
  logic [3:0]  align_we;

  always_comb begin
    load_held  = valid_q & memtoreg_q & ~done_q;
    // A response arriving in DRAIN belongs to an abandoned load
    rsp_live   = wb.rdata_ok & (state_q != WB_DRAIN);
    data_ready = ~memtoreg_q | buf_valid_q | rsp_live;
    commit     = valid_q & ~done_q & data_ready;
    abandon    = wb.FlushW | ~wb.StallW;
    if (wb.FlushW)
      next_load_pending = 1'b0;
    else if (!wb.StallW)
      next_load_pending = wb.ValidM & wb.MemtoRegM;
    else
      next_load_pending = load_held;
    load_rdata = buf_valid_q ? buf_q : wb.rdata;
  end

  load_align u_align (
    .mem_read_type_i (mrt_q),
    .addr_low_i      (addr_low_q),
    .rdata_i         (load_rdata),
    .alu_out_i       (alu_q),
    .mem_to_reg_i    (memtoreg_q),
    .data_o          (align_data),
    .byte_we_o       (align_we)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      regwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      mrt_q       <= 3'd0;
      addr_low_q  <= 2'd0;
      wreg_q      <= 7'd0;
      alu_q       <= 32'd0;
      hilo_we_q   <= 1'b0;
      hilo_q      <= 64'd0;
      done_q      <= 1'b0;
      buf_q       <= 32'd0;
      buf_valid_q <= 1'b0;
      state_q     <= WB_IDLE;
    end else begin
      if (wb.FlushW) begin
        valid_q     <= 1'b0;
        regwrite_q  <= 1'b0;
        memtoreg_q  <= 1'b0;
        mrt_q       <= 3'd0;
        addr_low_q  <= 2'd0;
        wreg_q      <= 7'd0;
        alu_q       <= 32'd0;
        hilo_we_q   <= 1'b0;
        hilo_q      <= 64'd0;
        done_q      <= 1'b0;
        buf_valid_q <= 1'b0;
      end else if (!wb.StallW) begin
        valid_q     <= wb.ValidM;
        regwrite_q  <= wb.RegWriteM;
        memtoreg_q  <= wb.MemtoRegM;
        mrt_q       <= wb.MemReadTypeM;
        addr_low_q  <= wb.AddrLowM;
        wreg_q      <= wb.WriteRegM;
        alu_q       <= wb.ALUOutM;
        hilo_we_q   <= wb.HI_LO_write_enableM;
        hilo_q      <= wb.HI_LO_dataM;
        done_q      <= 1'b0;
        buf_valid_q <= 1'b0;
      end else begin
        if (commit) done_q <= 1'b1;
        if (load_held && rsp_live) buf_valid_q <= 1'b1;
      end
      // Buffered data keeps ResultW stable while a committed load is held
      if (load_held && rsp_live) buf_q <= wb.rdata;

      case (state_q)
        WB_IDLE:
          if (load_held && !wb.rdata_ok) state_q <= abandon ? WB_DRAIN : WB_WAIT;
        WB_WAIT:
          if (wb.rdata_ok)   state_q <= WB_IDLE;
          else if (abandon)  state_q <= WB_DRAIN;
        WB_DRAIN:
          if (wb.rdata_ok)   state_q <= next_load_pending ? WB_WAIT : WB_IDLE;
        default:             state_q <= WB_IDLE;
      endcase
    end
  end

  assign wb.RegWriteW                  = commit & regwrite_q;
  assign wb.HI_LO_write_enable_from_WB = commit & hilo_we_q;
  assign wb.WriteRegW                  = wreg_q;
  assign wb.ResultW                    = align_data;
  assign wb.ForwardWB                  = align_data;
  assign wb.reg_file_byte_we           = valid_q ? align_we : 4'b0000;
  assign wb.HI_LO_data                 = hilo_q;
  assign wb.wb_stall_req = (load_held & ~data_ready) |
                           ((state_q == WB_DRAIN) & valid_q & memtoreg_q);

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - vector table plus write scoreboard for wb_stage
module tb_wb_stage;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_stage_if bus();
  wb_stage dut (.clk(clk), .rst(rst), .wb(bus));

  typedef struct {
    logic [6:0]  wreg;
    logic [31:0] data;
    logic [3:0]  we;
  } wr_t;

  typedef struct {
    logic        rw;
    logic        mtr;
    logic [2:0]  mrt;
    logic [1:0]  k;
    logic [6:0]  wreg;
    logic [31:0] alu;
    logic [31:0] rdata;
    int          lat;
    logic [31:0] exp_data;
    logic [3:0]  exp_we;
  } vec_t;

  int n_total = 0;
  int n_pass  = 0;
  int hilo_strobes = 0;
  wr_t wr_q[$];
  logic [63:0] hilo_exp_q[$];
  wr_t mon_e;
  logic [63:0] mon_h;
  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (bus.RegWriteW === 1'b1) begin
      if (wr_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: reg %0d data 0x%0h, expected no write",
                 bus.WriteRegW, bus.ResultW);
      end else begin
        mon_e = wr_q.pop_front();
        check("wreg", {57'd0, bus.WriteRegW}, {57'd0, mon_e.wreg});
        check("result", {32'd0, bus.ResultW}, {32'd0, mon_e.data});
        check("byte_we", {60'd0, bus.reg_file_byte_we}, {60'd0, mon_e.we});
        check("forward", {32'd0, bus.ForwardWB}, {32'd0, mon_e.data});
      end
    end
    if (bus.HI_LO_write_enable_from_WB === 1'b1) begin
      hilo_strobes++;
      if (hilo_exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_hilo_write: data 0x%0h, expected no write", bus.HI_LO_data);
      end else begin
        mon_h = hilo_exp_q.pop_front();
        check("hilo_data", bus.HI_LO_data, mon_h);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ValidM = 1'b0; bus.RegWriteM = 1'b0; bus.MemtoRegM = 1'b0;
    bus.MemReadTypeM = 3'd0; bus.AddrLowM = 2'd0; bus.WriteRegM = 7'd0;
    bus.ALUOutM = 32'd0; bus.HI_LO_write_enableM = 1'b0; bus.HI_LO_dataM = 64'd0;
    bus.StallW = 1'b0; bus.FlushW = 1'b0; bus.rdata_ok = 1'b0; bus.rdata = 32'd0;
  endtask

  task automatic issue_load(input logic [6:0] wreg);
    bus.ValidM = 1'b1; bus.RegWriteM = 1'b1; bus.MemtoRegM = 1'b1;
    bus.MemReadTypeM = 3'd0; bus.AddrLowM = 2'd0; bus.WriteRegM = wreg;
    bus.StallW = 1'b0; bus.FlushW = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_regwrite"}, {63'd0, bus.RegWriteW}, 64'd0);
    check({tag, "_wreg"}, {57'd0, bus.WriteRegW}, 64'd0);
    check({tag, "_result"}, {32'd0, bus.ResultW}, 64'd0);
    check({tag, "_byte_we"}, {60'd0, bus.reg_file_byte_we}, 64'd0);
    check({tag, "_hilo_we"}, {63'd0, bus.HI_LO_write_enable_from_WB}, 64'd0);
    check({tag, "_hilo"}, bus.HI_LO_data, 64'd0);
    check({tag, "_stall"}, {63'd0, bus.wb_stall_req}, 64'd0);
    check({tag, "_state"}, {62'd0, dut.state_q}, {62'd0, WB_IDLE});
  endtask

  task automatic apply(input vec_t v, input int idx);
    int stalls;
    wr_t e;
    bus.ValidM = 1'b1; bus.RegWriteM = v.rw; bus.MemtoRegM = v.mtr;
    bus.MemReadTypeM = v.mrt; bus.AddrLowM = v.k; bus.WriteRegM = v.wreg;
    bus.ALUOutM = v.alu; bus.StallW = 1'b0; bus.rdata_ok = 1'b0;
    if (v.rw) begin
      e.wreg = v.wreg; e.data = v.exp_data; e.we = v.exp_we;
      wr_q.push_back(e);
    end
    tick();
    bus.ValidM = 1'b0;
    stalls = 0;
    for (int c = 0; c <= v.lat; c++) begin
      if (c == v.lat) begin
        bus.rdata_ok = v.mtr; bus.rdata = v.rdata; bus.StallW = 1'b0;
      end else begin
        bus.rdata_ok = 1'b0; bus.rdata = 32'd0; bus.StallW = 1'b1;
      end
      @(negedge clk);
      if (bus.wb_stall_req === 1'b1) stalls++;
      tick();
    end
    bus.rdata_ok = 1'b0; bus.StallW = 1'b0;
    check($sformatf("vec%0d_stall_cycles", idx), 64'(stalls), 64'(v.mtr ? v.lat : 0));
    check($sformatf("vec%0d_pending_writes", idx), 64'(wr_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 3'd0, 2'd0, 7'd5,  32'h12345678, 32'h0,        0, 32'h12345678, 4'hF};
    vecs[1]  = '{1'b1, 1'b1, 3'd1, 2'd2, 7'd6,  32'h0, 32'h80FF7F01, 3, 32'hFFFFFFFF, 4'hF};
    vecs[2]  = '{1'b1, 1'b1, 3'd5, 2'd1, 7'd7,  32'h0, 32'hAABBCCDD, 0, 32'hCCDD0000, 4'hC};
    vecs[3]  = '{1'b1, 1'b1, 3'd6, 2'd1, 7'd7,  32'h0, 32'hAABBCCDD, 1, 32'h00AABBCC, 4'h7};
    vecs[4]  = '{1'b1, 1'b1, 3'd2, 2'd3, 7'd8,  32'h0, 32'h80FF7F01, 1, 32'h00000080, 4'hF};
    vecs[5]  = '{1'b1, 1'b1, 3'd3, 2'd2, 7'd9,  32'h0, 32'h80FF7F01, 2, 32'hFFFF80FF, 4'hF};
    vecs[6]  = '{1'b1, 1'b1, 3'd4, 2'd0, 7'd10, 32'h0, 32'h80FF7F01, 0, 32'h00007F01, 4'hF};
    vecs[7]  = '{1'b1, 1'b1, 3'd0, 2'd0, 7'd31, 32'h0, 32'hCAFEF00D, 2, 32'hCAFEF00D, 4'hF};
    vecs[8]  = '{1'b1, 1'b1, 3'd5, 2'd0, 7'd11, 32'h0, 32'hAABBCCDD, 0, 32'hDD000000, 4'h8};
    vecs[9]  = '{1'b1, 1'b1, 3'd5, 2'd3, 7'd12, 32'h0, 32'hAABBCCDD, 0, 32'hAABBCCDD, 4'hF};
    vecs[10] = '{1'b1, 1'b1, 3'd6, 2'd0, 7'd13, 32'h0, 32'hAABBCCDD, 0, 32'hAABBCCDD, 4'hF};
    vecs[11] = '{1'b1, 1'b1, 3'd6, 2'd3, 7'd14, 32'h0, 32'hAABBCCDD, 1, 32'h000000AA, 4'h1};
    vecs[12] = '{1'b0, 1'b0, 3'd0, 2'd0, 7'd15, 32'h0000FFFF, 32'h0, 0, 32'h0, 4'hF};
    vecs[13] = '{1'b1, 1'b1, 3'd1, 2'd0, 7'h45, 32'h0, 32'h80FF7F01, 0, 32'h00000001, 4'hF};
    vecs[14] = '{1'b1, 1'b1, 3'd3, 2'd0, 7'd16, 32'h0, 32'h00008001, 1, 32'hFFFF8001, 4'hF};

    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    tick();

    for (int i = 0; i < 15; i++) apply(vecs[i], i);

    // HI/LO write held under a 4-cycle stall must strobe once
    bus.ValidM = 1'b1; bus.RegWriteM = 1'b0; bus.MemtoRegM = 1'b0;
    bus.HI_LO_write_enableM = 1'b1; bus.HI_LO_dataM = 64'hDEADBEEF_00C0FFEE;
    hilo_exp_q.push_back(64'hDEADBEEF_00C0FFEE);
    tick();
    idle_inputs();
    bus.StallW = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("hilo_hold%0d", c), bus.HI_LO_data, 64'hDEADBEEF_00C0FFEE);
      tick();
    end
    bus.StallW = 1'b0;
    tick();
    check("hilo_strobe_count", 64'(hilo_strobes), 64'd1);
    check("hilo_pending", 64'(hilo_exp_q.size()), 64'd0);

    // Flush in WAIT: stale response discarded, next load gets its own
    issue_load(7'd20);
    tick();
    idle_inputs(); bus.StallW = 1'b1;
    @(negedge clk);
    check("flush_wait_stall", {63'd0, bus.wb_stall_req}, 64'd1);
    tick();
    check("flush_in_wait", {62'd0, dut.state_q}, {62'd0, WB_WAIT});
    bus.StallW = 1'b0; bus.FlushW = 1'b1;
    tick();
    check("drain_state", {62'd0, dut.state_q}, {62'd0, WB_DRAIN});
    issue_load(7'd21);
    wr_q.push_back('{7'd21, 32'h22222222, 4'hF});
    tick();
    idle_inputs(); bus.StallW = 1'b1; bus.rdata_ok = 1'b1; bus.rdata = 32'h11111111;
    @(negedge clk);
    check("drain_stall", {63'd0, bus.wb_stall_req}, 64'd1);
    tick();
    check("drain_to_wait", {62'd0, dut.state_q}, {62'd0, WB_WAIT});
    bus.StallW = 1'b0; bus.rdata = 32'h22222222;
    tick();
    idle_inputs();
    tick();
    check("drain_pending_writes", 64'(wr_q.size()), 64'd0);

    // Response and flush in the same WAIT cycle
    issue_load(7'd22);
    wr_q.push_back('{7'd22, 32'h33333333, 4'hF});
    tick();
    idle_inputs(); bus.StallW = 1'b1;
    tick();
    bus.StallW = 1'b0; bus.FlushW = 1'b1; bus.rdata_ok = 1'b1; bus.rdata = 32'h33333333;
    tick();
    idle_inputs();
    @(negedge clk);
    check("flush_ok_state", {62'd0, dut.state_q}, {62'd0, WB_IDLE});
    check("flush_ok_writes", 64'(wr_q.size()), 64'd0);
    tick();

    // Reset while waiting; a stray response afterwards is ignored
    issue_load(7'd23);
    tick();
    idle_inputs(); bus.StallW = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; bus.StallW = 1'b0;
    @(negedge clk);
    check_all_zero("rst_wait");
    tick();
    bus.rdata_ok = 1'b1; bus.rdata = 32'h44444444;
    @(negedge clk);
    check("stray_stall", {63'd0, bus.wb_stall_req}, 64'd0);
    tick();
    idle_inputs();
    @(negedge clk);
    check("stray_state", {62'd0, dut.state_q}, {62'd0, WB_IDLE});
    tick();
    check("final_pending_writes", 64'(wr_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
